// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the coordinate type used by the scan
// generator and the pixel mappers.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

endpackage

// File: rtl/sync_delay.sv
// DEPTH-stage x WIDTH-bit shift register with a per-bit reset value;
// DEPTH = 0 degenerates to a wire.
module sync_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] tap [DEPTH+1];

            assign tap[0] = din;
            assign dout   = tap[DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] q_reg;

                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        q_reg <= RST_VAL;
                    end else begin
                        q_reg <= tap[gi];
                    end
                end

                assign tap[gi+1] = q_reg;
            end
        end
    endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// Free-running raster scan generator: pixel/line counters, visible-area and
// sync decodes, pipeline-aligned sync outputs and a per-frame tick/counter.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int PIPE_DLY  = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       blank_d,
    output logic       hs,
    output logic       vs,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int H_SUM = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_SUM = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_SUM - 1);
    localparam coord_t V_LAST     = coord_t'(V_SUM - 1);
    localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
    localparam coord_t HSYNC_LO_C = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HSYNC_HI_C = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VSYNC_LO_C = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VSYNC_HI_C = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    // Totals are the largest sums; if they fit in 10 bits every decode does.
    generate
        if (H_SUM > 1023 || V_SUM > 1023) begin : g_bad_sum
            $error("vga_scan_gen: timing sums exceed 10-bit coordinate range");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_scan_gen: PIPE_DLY must be 0..4");
        end
    endgenerate

    coord_t     hc_reg, hc_next;
    coord_t     vc_reg, vc_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;
    logic       hs_raw, vs_raw;

    assign blank      = (hc_reg < H_VIS_C) && (vc_reg < V_VIS_C);
    assign hs_raw     = !((hc_reg >= HSYNC_LO_C) && (hc_reg < HSYNC_HI_C));
    assign vs_raw     = !((vc_reg >= VSYNC_LO_C) && (vc_reg < VSYNC_HI_C));
    assign frame_tick = (hc_reg == '0) && (vc_reg == V_VIS_C);

    always_comb begin
        hc_next        = (hc_reg == H_LAST) ? '0 : hc_reg + 10'd1;
        vc_next        = vc_reg;
        frame_cnt_next = frame_cnt_reg;
        if (hc_reg == H_LAST) begin
            vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 10'd1;
        end
        if (frame_tick) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
        end
    end

    // Reset parks on the last pixel so the first free-running edge lands on (0,0).
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_reg        <= H_LAST;
            vc_reg        <= V_LAST;
            frame_cnt_reg <= '0;
        end else begin
            hc_reg        <= hc_next;
            vc_reg        <= vc_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign DrawX     = hc_reg;
    assign DrawY     = vc_reg;
    assign frame_cnt = frame_cnt_reg;

    sync_delay #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .din     ({hs_raw, vs_raw, blank}),
        .dout    ({hs, vs, blank_d})
    );

endmodule
